// File: rtl/serial_pkg.sv
// Shared frame definition for the serial serializer/deserializer pair.
// Holds the FSM state enum, the default payload width and the frame length.
// Optional feature macro: DESER_PARITY_EN (adds one even-parity bit per frame).
package serial_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

`ifdef DESER_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Start + stop bits, plus the parity bit when enabled
  localparam int unsigned FRAME_OVERHEAD = 2 + PARITY_BITS;
  localparam int unsigned FRAME_LEN      = DEFAULT_DATA_WIDTH + FRAME_OVERHEAD;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_STOP   = 3'd2,
    ST_BREAK  = 3'd3
`ifdef DESER_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } deser_state_e;

endpackage

// File: rtl/serial_deserializer_if.sv
// Output word handshake of the serial deserializer (one-entry valid/ready register).
//   data  : recovered word
//   valid : data holds an unconsumed word
//   ready : consumer accepts the word when valid && ready
// master = producer (deserializer), slave = consumer.
interface serial_deserializer_if
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/serial_deserializer.sv
// Serial deserializer: recovers DATA_WIDTH-bit words from start/data/stop frames
// sampled one bit per clk_i cycle, presenting each on a one-entry valid/ready register.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   data_i       : serial line (idles high), already synchronous to clk_i
//   out_if       : master side of the output word handshake (data/valid/ready)
//   busy_o       : a frame is in progress (FSM not idle)
//   frame_err_o  : 1-cycle pulse on a bad stop bit (or bad parity)
//   overrun_o    : 1-cycle pulse when a good word is dropped because the output is full
// Optional feature macro: DESER_PARITY_EN (even parity bit between data and stop).
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
)
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_i,
  serial_deserializer_if.master out_if,
  output logic                  busy_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  deser_state_e            state_q, state_n;
  logic [CNT_W-1:0]        cnt_q, cnt_n;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_n;
  logic [DATA_WIDTH-1:0]   data_q, data_n;
  logic                    valid_q, valid_n;
  logic                    busy_q;
  logic                    frame_err_q, frame_err_n;
  logic                    overrun_q, overrun_n;
`ifdef DESER_PARITY_EN
  logic                    par_bad_q, par_bad_n;
`endif

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef DESER_PARITY_EN
      par_bad_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      shreg_q     <= shreg_n;
      data_q      <= data_n;
      valid_q     <= valid_n;
      busy_q      <= (state_n != ST_IDLE);
      frame_err_q <= frame_err_n;
      overrun_q   <= overrun_n;
`ifdef DESER_PARITY_EN
      par_bad_q   <= par_bad_n;
`endif
    end
  end

  // Next-state, shift register and output register update
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    shreg_n     = shreg_q;
    data_n      = data_q;
    valid_n     = valid_q;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
`ifdef DESER_PARITY_EN
    par_bad_n   = par_bad_q;
`endif

    // Consumer handshake; a load below overrides the clear
    if (valid_q && out_if.ready) begin
      valid_n = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // Start bit is consumed in the cycle it is seen
        if (!data_i) begin
          state_n = ST_DATA;
          cnt_n   = '0;
        end
      end

      ST_DATA: begin
        shreg_n[cnt_q] = data_i;
        if (cnt_q == CNT_LAST) begin
`ifdef DESER_PARITY_EN
          state_n = ST_PARITY;
`else
          state_n = ST_STOP;
`endif
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

`ifdef DESER_PARITY_EN
      ST_PARITY: begin
        // Even parity: parity bit equals XOR of the data bits
        par_bad_n   = ((^shreg_q) != data_i);
        frame_err_n = ((^shreg_q) != data_i);
        state_n     = ST_STOP;
      end
`endif

      ST_STOP: begin
`ifdef DESER_PARITY_EN
        // Parity failure was already flagged; the stop bit is just consumed
        if (par_bad_q) begin
          state_n = ST_IDLE;
        end else
`endif
        if (data_i) begin
          state_n = ST_IDLE;
          if (!valid_q || out_if.ready) begin
            data_n  = shreg_q;
            valid_n = 1'b1;
          end else begin
            overrun_n = 1'b1;
          end
        end else begin
          frame_err_n = 1'b1;
          state_n     = ST_BREAK;
        end
      end

      ST_BREAK: begin
        // Wait out a held-low line so it yields a single error
        if (data_i) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;
  assign busy_o       = busy_q;
  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;

endmodule
